// File: rtl/arq_send_ctrl.sv
// arq_send_ctrl: stop-and-wait ARQ sender with sequence numbers, timeout retransmit
// and a sticky link error after the retry budget is exhausted.
module arq_send_ctrl #(
    parameter int SEQ_BITS = 1,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRIES = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                enable,
    input  logic                ctrl_req,
    input  logic                data_req,
    output logic                send_start,
    output logic                send_kind,
    output logic [SEQ_BITS-1:0] send_seq,
    input  logic                send_done,
    input  logic                ack_received,
    input  logic [SEQ_BITS-1:0] ack_seq,
    output logic                ctrl_taken,
    output logic                data_taken,
    output logic                busy,
    output logic                link_error,
    input  logic                err_clear,
    output logic [RW-1:0]       retry_cnt,
    output logic [3:0]          ack_cnt
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, WAIT_ACK, ERROR} state_t;

    state_t              state, state_d;
    logic [SEQ_BITS-1:0] cur_seq;
    logic [TW-1:0]       timer;
    logic                kind, accept, retry, abort, expired;

    assign expired = timer == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        retry   = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE:      state_d = (enable && (ctrl_req || data_req)) ? SEND : IDLE;
            SEND: begin
                abort   = !enable;
                state_d = enable ? WAIT_DONE : IDLE;
            end
            WAIT_DONE: begin
                abort   = !enable;
                state_d = !enable ? IDLE : send_done ? WAIT_ACK : WAIT_DONE;
            end
            WAIT_ACK: begin
                // a matching ACK beats a timeout landing in the same cycle
                abort   = !enable;
                accept  = enable && ack_received && ack_seq == cur_seq;
                retry   = enable && !accept && expired && retry_cnt != RW'(MAX_RETRIES);
                state_d = (!enable || accept) ? IDLE : expired ? (retry ? SEND : ERROR) : WAIT_ACK;
            end
            ERROR:     state_d = err_clear ? IDLE : ERROR;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            cur_seq    <= '0;
            retry_cnt  <= '0;
            ack_cnt    <= '0;
            timer      <= '0;
            kind       <= 1'b0;
            ctrl_taken <= 1'b0;
            data_taken <= 1'b0;
        end else begin
            state      <= state_d;
            kind       <= (state == IDLE && state_d == SEND) ? ctrl_req : kind;
            cur_seq    <= accept ? cur_seq + 1'b1 : cur_seq;
            ack_cnt    <= accept ? ack_cnt + 4'd1 : ack_cnt;
            retry_cnt  <= (accept || abort || (state == ERROR && err_clear)) ? '0 :
                          retry ? retry_cnt + 1'b1 : retry_cnt;
            timer      <= (state == WAIT_DONE) ? '0 :
                          (state == WAIT_ACK && timer != TW'(TIMEOUT_CYCLES)) ? timer + 1'b1 : timer;
            ctrl_taken <= accept && kind;
            data_taken <= accept && !kind;
        end
    end

    assign send_start = state == SEND;
    assign send_kind  = send_start && kind;
    assign send_seq   = send_start ? cur_seq : '0;
    assign busy       = state != IDLE;
    assign link_error = state == ERROR;
endmodule

// File: tb/tb_arq_send_ctrl.sv
// tb_arq_send_ctrl: directed scenario tests for arq_send_ctrl (SEQ_BITS=2, TIMEOUT=8, MAX_RETRIES=2).
module tb_arq_send_ctrl;
    logic       clk = 0, rst_l = 0, enable = 0, ctrl_req = 0, data_req = 0;
    logic       send_done = 0, ack_received = 0, err_clear = 0;
    logic [1:0] ack_seq = 0;
    logic       send_start, send_kind, ctrl_taken, data_taken, busy, link_error;
    logic [1:0] send_seq, retry_cnt;
    logic [3:0] ack_cnt;
    int errors = 0, checks = 0;
    int n_start = 0, n_ctrl = 0, n_data = 0, n_both = 0;

    arq_send_ctrl #(.SEQ_BITS(2), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) dut (
        .clk(clk), .rst_l(rst_l), .enable(enable), .ctrl_req(ctrl_req), .data_req(data_req),
        .send_start(send_start), .send_kind(send_kind), .send_seq(send_seq),
        .send_done(send_done), .ack_received(ack_received), .ack_seq(ack_seq),
        .ctrl_taken(ctrl_taken), .data_taken(data_taken), .busy(busy),
        .link_error(link_error), .err_clear(err_clear), .retry_cnt(retry_cnt), .ack_cnt(ack_cnt)
    );

    always #5 clk = ~clk;

    // pulse tallies, sampled mid-cycle so task snapshots at negedge are race-free
    always begin
        @(posedge clk);
        #2;
        n_start += int'(send_start);
        n_ctrl  += int'(ctrl_taken);
        n_data  += int'(data_taken);
        n_both  += int'(ctrl_taken && data_taken);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_l = 0; enable = 0; ctrl_req = 0; data_req = 0;
        send_done = 0; ack_received = 0; ack_seq = 0; err_clear = 0;
        repeat (2) @(negedge clk);
        rst_l = 1;
        @(negedge clk);
    endtask

    task automatic wait_start(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = send_start;
        end
    endtask

    // from the SEND-cycle negedge: advance into WAIT_DONE, pulse send_done, end on the WAIT_ACK entry cycle
    task automatic to_wait_ack();
        @(negedge clk);
        send_done = 1;
        @(negedge clk);
        send_done = 0;
    endtask

    task automatic test_reset();
        rst_l = 0;
        @(negedge clk);
        checks++; if ({send_start, send_kind, send_seq, ctrl_taken, data_taken} !== 6'b0) begin errors++; $display("FAIL reset_send got=%b want=0", {send_start, send_kind, send_seq, ctrl_taken, data_taken}); end
        checks++; if ({busy, link_error, retry_cnt, ack_cnt} !== 8'b0) begin errors++; $display("FAIL reset_status got=%b want=0", {busy, link_error, retry_cnt, ack_cnt}); end
        do_reset();
    endtask

    task automatic test_basic();
        bit ok;
        enable = 1; data_req = 1;
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_start got=timeout want=send_start"); end
        checks++; if ({send_kind, send_seq, busy} !== 4'b0001) begin errors++; $display("FAIL basic_first got kind/seq/busy=%b want=0001", {send_kind, send_seq, busy}); end
        repeat (2) @(negedge clk);
        send_done = 1;
        @(negedge clk);
        send_done = 0;
        @(negedge clk);
        ack_received = 1; ack_seq = 0;
        @(negedge clk);
        ack_received = 0;
        checks++; if ({data_taken, ctrl_taken, busy} !== 3'b100) begin errors++; $display("FAIL basic_taken got d/c/busy=%b want=100", {data_taken, ctrl_taken, busy}); end
        checks++; if (ack_cnt !== 4'd1) begin errors++; $display("FAIL basic_ack_cnt got=%0d want=1", ack_cnt); end
        @(negedge clk);
        checks++; if ({data_taken, send_start, send_seq} !== 4'b0101) begin errors++; $display("FAIL basic_next got taken/start/seq=%b want=0101", {data_taken, send_start, send_seq}); end
        do_reset();
    endtask

    task automatic test_priority_wrap();
        bit ok;
        int s0, c0, d0;
        s0 = n_start; c0 = n_ctrl; d0 = n_data;
        enable = 1; ctrl_req = 1; data_req = 1;
        for (int i = 0; i < 5; i++) begin
            wait_start(ok);
            checks++; if (!ok || send_kind !== 1'b1 || send_seq !== 2'(i)) begin errors++; $display("FAIL prio_send%0d got ok/kind/seq=%0b/%0b/%0d want 1/1/%0d", i, ok, send_kind, send_seq, i % 4); end
            to_wait_ack();
            ack_received = 1; ack_seq = 2'(i);
            @(negedge clk);
            ack_received = 0;
            if (i == 4) begin ctrl_req = 0; data_req = 0; end
            checks++; if ({ctrl_taken, data_taken} !== 2'b10) begin errors++; $display("FAIL prio_taken%0d got c/d=%b want=10", i, {ctrl_taken, data_taken}); end
        end
        repeat (3) @(negedge clk);
        checks++; if (n_start - s0 != 5 || n_ctrl - c0 != 5 || n_data - d0 != 0) begin errors++; $display("FAIL prio_counts got start/ctrl/data=%0d/%0d/%0d want 5/5/0", n_start - s0, n_ctrl - c0, n_data - d0); end
        checks++; if (ack_cnt !== 4'd5) begin errors++; $display("FAIL prio_ack_cnt got=%0d want=5", ack_cnt); end
        do_reset();
    endtask

    task automatic test_retransmit();
        bit ok;
        int early = 0;
        enable = 1; data_req = 1;
        wait_start(ok);
        to_wait_ack();
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            early += int'(send_start);
        end
        @(negedge clk);
        checks++; if (early != 0) begin errors++; $display("FAIL retx_early got=%0d starts want=0", early); end
        checks++; if ({send_start, send_kind, send_seq, retry_cnt} !== 6'b100001) begin errors++; $display("FAIL retx_start got start/kind/seq/retry=%b want=100001", {send_start, send_kind, send_seq, retry_cnt}); end
        to_wait_ack();
        ack_received = 1; ack_seq = 0; data_req = 0;
        @(negedge clk);
        ack_received = 0;
        checks++; if ({data_taken, retry_cnt, ack_cnt} !== 7'b1000001) begin errors++; $display("FAIL retx_ack got taken/retry/ack_cnt=%b want=1000001", {data_taken, retry_cnt, ack_cnt}); end
        do_reset();
    endtask

    task automatic test_error();
        bit ok;
        int s0, n;
        s0 = n_start;
        enable = 1; data_req = 1;
        for (int i = 0; i < 3; i++) begin
            wait_start(ok);
            if (i == 0) data_req = 0;
            checks++; if (!ok || retry_cnt !== 2'(i) || send_seq !== 2'd0) begin errors++; $display("FAIL err_attempt%0d got ok/retry/seq=%0b/%0d/%0d want 1/%0d/0", i, ok, retry_cnt, send_seq, i); end
            to_wait_ack();
        end
        n = 0;
        while (!link_error && n < 20) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        checks++; if ({link_error, busy} !== 2'b11) begin errors++; $display("FAIL err_state got link_error/busy=%b want=11", {link_error, busy}); end
        checks++; if (n_start - s0 != 3) begin errors++; $display("FAIL err_starts got=%0d want=3", n_start - s0); end
        err_clear = 1;
        @(negedge clk);
        err_clear = 0;
        checks++; if ({link_error, busy, retry_cnt} !== 4'b0) begin errors++; $display("FAIL err_clear got link_error/busy/retry=%b want=0000", {link_error, busy, retry_cnt}); end
        data_req = 1;
        wait_start(ok);
        data_req = 0;
        checks++; if (!ok || send_seq !== 2'd0) begin errors++; $display("FAIL err_resend got ok/seq=%0b/%0d want 1/0", ok, send_seq); end
        do_reset();
    endtask

    task automatic test_stale_boundary();
        bit ok;
        int s0;
        enable = 1; data_req = 1;
        wait_start(ok);
        s0 = n_start;
        to_wait_ack();
        ack_received = 1; ack_seq = 3;
        @(negedge clk);
        ack_received = 0;
        checks++; if ({busy, data_taken, ack_cnt} !== 6'b100000) begin errors++; $display("FAIL stale_ack got busy/taken/ack_cnt=%b want=100000", {busy, data_taken, ack_cnt}); end
        repeat (6) @(negedge clk);
        ack_received = 1; ack_seq = 0;
        @(negedge clk);
        ack_received = 0; data_req = 0;
        checks++; if ({data_taken, send_start, busy, ack_cnt} !== 7'b1000001) begin errors++; $display("FAIL boundary_ack got taken/start/busy/ack_cnt=%b want=1000001", {data_taken, send_start, busy, ack_cnt}); end
        repeat (10) @(negedge clk);
        checks++; if (n_start != s0) begin errors++; $display("FAIL boundary_noretx got=%0d extra starts want=0", n_start - s0); end
        do_reset();
    endtask

    task automatic test_abort_reset();
        bit ok;
        enable = 1; data_req = 1;
        wait_start(ok);
        to_wait_ack();
        ack_received = 1; ack_seq = 0;
        @(negedge clk);
        ack_received = 0;
        wait_start(ok);
        to_wait_ack();
        enable = 0;
        @(negedge clk);
        checks++; if ({busy, data_taken, ctrl_taken, retry_cnt} !== 5'b0) begin errors++; $display("FAIL abort_idle got busy/d/c/retry=%b want=00000", {busy, data_taken, ctrl_taken, retry_cnt}); end
        enable = 1;
        wait_start(ok);
        checks++; if (!ok || send_seq !== 2'd1) begin errors++; $display("FAIL abort_resend got ok/seq=%0b/%0d want 1/1", ok, send_seq); end
        @(negedge clk);
        rst_l = 0;
        #1;
        checks++; if ({send_start, busy, send_seq, ack_cnt, retry_cnt, link_error} !== 11'b0) begin errors++; $display("FAIL async_reset got=%b want=0", {send_start, busy, send_seq, ack_cnt, retry_cnt, link_error}); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority_wrap();
        test_retransmit();
        test_error();
        test_stale_boundary();
        test_abort_reset();
        checks++; if (n_both != 0) begin errors++; $display("FAIL taken_exclusive got=%0d overlaps want=0", n_both); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arq_send_ctrl.md
# arq_send_ctrl

Parametrised stop-and-wait ARQ controller for the inter-board link. It sits between the game-side request sources (control packets such as ready/lost, and board data updates) and the serial sender. It issues sequence-numbered sends, waits for a matching ACK from the receiver path, and retransmits on timeout. After a bounded number of retries it raises a sticky link error. It generalises the single-bit, fixed-kind ACK handling with configurable sequence width, timeout, retry limit and packet priority.

## Interface
- SEQ_BITS, default 1: sequence number width; sequence wraps modulo 2^SEQ_BITS.
- TIMEOUT_CYCLES, default 1000: ACK wait window in clk cycles; must be >= 2.
- MAX_RETRIES, default 3: retransmissions allowed before error; must be >= 0.

- clk  in  1  system clock; all logic is rising-edge.
- rst_l  in  1  asynchronous, active-low reset.
- enable  in  1  link enabled; low aborts any transaction in progress.
- ctrl_req  in  1  control packet pending (level); has priority over data.
- data_req  in  1  data packet pending (level).
- send_start  out  1  one-cycle pulse that starts the serializer.
- send_kind  out  1  packet kind, valid with send_start: 1 = ctrl, 0 = data.
- send_seq  out  SEQ_BITS  sequence number, valid with send_start.
- send_done  in  1  serializer-finished pulse.
- ack_received  in  1  ACK pulse from the receiver.
- ack_seq  in  SEQ_BITS  sequence number carried by the ACK.
- ctrl_taken  out  1  one-cycle pulse: ctrl packet acknowledged.
- data_taken  out  1  one-cycle pulse: data packet acknowledged.
- busy  out  1  high in every state except IDLE.
- link_error  out  1  sticky; high in ERROR.
- err_clear  in  1  leaves ERROR.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  retries spent on the current packet.
- ack_cnt  out  4  count of accepted ACKs, wraps 15 -> 0 (display use).

## Operation
- States: IDLE, SEND, WAIT_DONE, WAIT_ACK, ERROR.
- Reset: state IDLE; cur_seq, retry_cnt, ack_cnt, timer and kind are 0; all outputs 0.
- IDLE: when enable and (ctrl_req or data_req), latch kind (ctrl wins if both are high) and go to SEND.
- SEND: send_start=1 (Moore), with send_seq=cur_seq and send_kind=latched kind; go to WAIT_DONE next cycle.
- WAIT_DONE: on send_done, clear timer and go to WAIT_ACK.
- WAIT_ACK: timer counts 0,1,... starting on the entry cycle.
  - If ack_received and ack_seq==cur_seq: pulse taken for the latched kind, increment cur_seq (wrap), clear retry_cnt, increment ack_cnt, go to IDLE.
  - Else if timer==TIMEOUT_CYCLES-1: if retry_cnt==MAX_RETRIES go to ERROR; otherwise increment retry_cnt and go to SEND with the same seq and kind.
  - An ACK with a mismatched seq is a stale duplicate: ignore it and do not count it.
- ERROR: link_error=1, no sends. On err_clear go to IDLE and clear retry_cnt; cur_seq is unchanged.
- enable low in SEND, WAIT_DONE or WAIT_ACK: next state IDLE, retry_cnt cleared, cur_seq held, no taken pulse. enable has no effect in ERROR.
- send_done outside WAIT_DONE and ack_received outside WAIT_ACK are ignored.
- A request dropped while in flight does not cancel the transaction; taken still pulses on ACK.

## Timing
- A request sampled in IDLE at edge k puts send_start high during cycle k+1.
- send_start is exactly one cycle wide per transmission, including retransmissions.
- A matching ACK sampled at edge a: taken pulse and state IDLE in cycle a+1. The earliest next send_start is cycle a+2.
- WAIT_ACK entered at cycle e: an ACK is accepted through cycle e+TIMEOUT_CYCLES-1 inclusive. The retransmit send_start occurs in cycle e+TIMEOUT_CYCLES.
- If a matching ACK and the timeout occur in the same cycle, the ACK wins.
- ctrl_taken and data_taken are never high together.
- Timer width is $clog2(TIMEOUT_CYCLES+1). The timer saturates and is only meaningful in WAIT_ACK.
- Asynchronous reset mid-transaction returns all state to reset values immediately; no pulse is emitted after reset.

## Test plan
Parameters for all cases: SEQ_BITS=2, TIMEOUT_CYCLES=8, MAX_RETRIES=2.
- Basic send: data_req=1, send_done 3 cycles after send_start, ACK seq 0 two cycles later -> send_start with kind 0 / seq 0, data_taken 1 cycle, then next send uses seq 1, ack_cnt=1.
- Priority and wrap: ctrl_req and data_req both high for 5 ACKed transactions -> all sends are kind 1; seq runs 0,1,2,3,0; ctrl_taken pulses 5 times and data_taken never pulses.
- Retransmit: no ACK after the first send_done -> send_start again at e+8 with seq 0 and retry_cnt=1; an ACK for seq 0 on the second attempt -> data_taken, retry_cnt=0.
- Error: no ACKs at all -> exactly 3 send_starts, then link_error=1 and busy=1. err_clear -> IDLE, link_error=0; the next send uses seq 0.
- Stale ACK and boundary: ACK seq 3 while waiting on seq 0 -> ignored, ack_cnt unchanged. Matching ACK in cycle e+7 -> accepted, no retransmit.
- Abort: enable drops in WAIT_ACK -> IDLE next cycle, no taken pulse. Re-enable -> resend with the same seq. Assert rst_l=0 in WAIT_DONE -> all outputs 0 immediately.
